multicycle_controller: RTL and testbench

Parametrised multi-cycle control FSM for the RISC-V RV32I core, replacing the single-cycle combinational opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states over a shared ALU and a single memory port with a ready handshake. It also detects illegal opcodes and memory timeouts and halts in a sticky trap state. It sits between the instruction register and the multi-cycle datapath's muxes and register enables.

---
 rtl/multicycle_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I control FSM. Steps each instruction through fetch,
//   decode, execute, memory and writeback over a shared ALU and a single
//   ready-handshaked memory port. Illegal opcodes and memory-wait timeouts
//   park the FSM in a sticky TRAP state that only reset leaves.
//
// Ports
//   clk, rst_n      rising-edge clock, async active-low reset
//   instruction     instruction register contents (opcode = [6:0])
//   mem_ready       memory handshake, completes the access in its cycle
//   branch_taken    branch comparison result, used in BRANCH only
//   ir_write        IR / old_pc load enable
//   pc_write        PC enable
//   pc_src          0 = result mux, 1 = ALUOut
//   adr_src         0 = PC, 1 = ALUOut
//   mem_read/write  memory strobes
//   alu_src_a       00 PC, 01 old_pc, 10 rs1, 11 zero
//   alu_src_b       00 rs2, 01 imm, 10 const 4
//   alu_op          00 add, 01 branch compare, 10 funct-decoded
//   result_src      00 ALUOut, 01 mem data, 10 ALU direct, 11 imm
//   reg_write       register-file write enable
//   instr_retired   pulse in the last cycle of every instruction
//   fault           00 none, 01 illegal opcode, 10 bus timeout
//   state           current state, for debug
module multicycle_controller #(
    parameter int INSTRUCTION_LEN = 32,
    parameter int MEM_TIMEOUT     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INSTRUCTION_LEN-1:0] instruction,
    input  logic                       mem_ready,
    input  logic                       branch_taken,
    output logic                       ir_write,
    output logic                       pc_write,
    output logic                       pc_src,
    output logic                       adr_src,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [1:0]                 alu_src_a,
    output logic [1:0]                 alu_src_b,
    output logic [1:0]                 alu_op,
    output logic [1:0]                 result_src,
    output logic                       reg_write,
    output logic                       instr_retired,
    output logic [1:0]                 fault,
    output logic [3:0]                 state
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADDR, S_JUMP,
        S_LUI_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BR    = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_AUIPC = 7'd23;

    // Keep at least one bit so MEM_TIMEOUT=0 (timeout disabled) still elaborates.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    fault_q, fault_nxt;
    logic [6:0]    opcode;
    logic          waiting, expire;
    logic          unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign unused_instr_bits = ^instruction[INSTRUCTION_LEN-1:7];

    // A wait cycle is any cycle in a handshake state without mem_ready.
    // The counter only survives while the FSM keeps waiting, so any entry
    // into a handshake state starts it from zero.
    assign waiting = (cur == S_FETCH || cur == S_MEM_READ || cur == S_MEM_WRITE) && !mem_ready;
    assign expire  = (MEM_TIMEOUT != 0) && waiting && (cnt == LAST);
    assign cnt_nxt = waiting ? cnt + 1'b1 : '0;

    assign fault = fault_q;
    assign state = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_FETCH;
            cnt     <= '0;
            fault_q <= 2'b00;
        end else begin
            cur     <= nxt;
            cnt     <= cnt_nxt;
            fault_q <= fault_nxt;
        end
    end

    always_comb begin
        nxt           = cur;
        fault_nxt     = fault_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        reg_write     = 1'b0;
        instr_retired = 1'b0;

        case (cur)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) nxt = S_DECODE;
                else if (expire) begin
                    nxt       = S_TRAP;
                    fault_nxt = 2'b10;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
                    OP_R:              nxt = S_EXEC_R;
                    OP_I:              nxt = S_EXEC_I;
                    OP_BR:             nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JUMP;
                    OP_JALR:           nxt = S_JALR_ADDR;
                    OP_LUI:            nxt = S_LUI_WB;
                    OP_AUIPC:          nxt = S_ALU_WB;
                    default: begin
                        nxt       = S_TRAP;
                        fault_nxt = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
                else if (expire) begin
                    nxt       = S_TRAP;
                    fault_nxt = 2'b10;
                end
            end
            S_MEM_WB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                nxt           = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    nxt           = S_FETCH;
                end else if (expire) begin
                    nxt       = S_TRAP;
                    fault_nxt = 2'b10;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                nxt           = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b10;
                alu_op        = 2'b01;
                pc_src        = 1'b1;
                pc_write      = branch_taken;
                instr_retired = 1'b1;
                nxt           = S_FETCH;
            end
            S_JALR_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = S_JUMP;
            end
            S_JUMP: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b10;
                result_src    = 2'b10;
                reg_write     = 1'b1;
                pc_src        = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                nxt           = S_FETCH;
            end
            S_LUI_WB: begin
                result_src    = 2'b11;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                nxt           = S_FETCH;
            end
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase

        // Reset holds the FSM in FETCH; its strobes must not leak out meanwhile.
        if (!rst_n) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n, mem_ready, branch_taken;
    logic [31:0] instruction;
    logic        ir_write, pc_write, pc_src, adr_src, mem_read, mem_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, fault;
    logic        reg_write, instr_retired;
    logic [3:0]  state;

    int checks = 0;
    int failures = 0;

    multicycle_controller #(.INSTRUCTION_LEN(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .reg_write(reg_write), .instr_retired(instr_retired),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [5:0] strobes();
        return {ir_write, pc_write, mem_read, mem_write, reg_write, instr_retired};
    endfunction

    function automatic logic [31:0] mk_instr(input logic [6:0] op);
        return ($urandom() & 32'hFFFF_FF80) | {25'd0, op};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first FETCH cycle after reset.
    task automatic drive_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        branch_taken = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        instruction = mk_instr(7'd51);
        #2;
        checks++; if (strobes() !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=000000", strobes()); end
        checks++; if (fault !== 2'b00) begin failures++; $display("FAIL reset_fault got=%b exp=00", fault); end
        checks++; if ({adr_src, alu_src_a, alu_src_b, result_src} !== 7'b0_00_10_10)
            begin failures++; $display("FAIL reset_selects got=%b exp=0001010", {adr_src, alu_src_a, alu_src_b, result_src}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (strobes() !== 6'b0) begin failures++; $display("FAIL reset_held_strobes got=%b exp=000000", strobes()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({mem_read, ir_write, pc_write} !== 3'b111) begin failures++; $display("FAIL reset_first_fetch got=%b exp=111", {mem_read, ir_write, pc_write}); end
        next_cycle();
    endtask

    task automatic test_rtype();
        drive_reset();
        instruction = mk_instr(7'd51);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (reg_write !== (c == 4)) begin failures++; $display("FAIL rtype_reg_write c=%0d got=%b exp=%b", c, reg_write, c == 4); end
            checks++; if (instr_retired !== (c == 4)) begin failures++; $display("FAIL rtype_retire c=%0d got=%b exp=%b", c, instr_retired, c == 4); end
            if (c == 1 || c == 5) begin
                checks++; if ({ir_write, pc_write, mem_read} !== 3'b111) begin failures++; $display("FAIL rtype_fetch c=%0d got=%b exp=111", c, {ir_write, pc_write, mem_read}); end
            end
            if (c == 2) begin
                checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b01_01_00) begin failures++; $display("FAIL rtype_decode got=%b exp=010100", {alu_src_a, alu_src_b, alu_op}); end
            end
            if (c == 3) begin
                checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_00_10) begin failures++; $display("FAIL rtype_exec got=%b exp=100010", {alu_src_a, alu_src_b, alu_op}); end
            end
            if (c == 4) begin
                checks++; if (result_src !== 2'b00) begin failures++; $display("FAIL rtype_result_src got=%b exp=00", result_src); end
            end
            next_cycle();
        end
    endtask

    task automatic test_load_wait();
        drive_reset();
        instruction = mk_instr(7'd3);
        for (int c = 1; c <= 9; c++) begin
            mem_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            checks++; if (instr_retired !== (c == 8)) begin failures++; $display("FAIL load_retire c=%0d got=%b exp=%b", c, instr_retired, c == 8); end
            checks++; if (reg_write !== (c == 8)) begin failures++; $display("FAIL load_reg_write c=%0d got=%b exp=%b", c, reg_write, c == 8); end
            checks++; if (mem_read !== (c == 1 || (c >= 4 && c <= 7) || c == 9))
                begin failures++; $display("FAIL load_mem_read c=%0d got=%b", c, mem_read); end
            if (c >= 4 && c <= 7) begin
                checks++; if (adr_src !== 1'b1) begin failures++; $display("FAIL load_adr_src c=%0d got=%b exp=1", c, adr_src); end
            end
            if (c == 8) begin
                checks++; if (result_src !== 2'b01) begin failures++; $display("FAIL load_result_src got=%b exp=01", result_src); end
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            drive_reset();
            instruction = mk_instr(7'd99);
            branch_taken = t[0];
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                checks++; if (instr_retired !== (c == 3)) begin failures++; $display("FAIL branch_retire t=%0d c=%0d got=%b", t, c, instr_retired); end
                if (c == 3) begin
                    checks++; if (pc_write !== t[0]) begin failures++; $display("FAIL branch_pc_write t=%0d got=%b exp=%b", t, pc_write, t[0]); end
                    checks++; if ({pc_src, alu_op, reg_write} !== 4'b1_01_0) begin failures++; $display("FAIL branch_ctl t=%0d got=%b exp=1010", t, {pc_src, alu_op, reg_write}); end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_jalr();
        drive_reset();
        instruction = mk_instr(7'd103);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if ({reg_write, instr_retired} !== {2{c == 4}}) begin failures++; $display("FAIL jalr_wb c=%0d got=%b", c, {reg_write, instr_retired}); end
            checks++; if (pc_write !== (c == 1 || c == 4)) begin failures++; $display("FAIL jalr_pc_write c=%0d got=%b", c, pc_write); end
            if (c == 3) begin
                checks++; if ({alu_src_a, alu_src_b} !== 4'b10_01) begin failures++; $display("FAIL jalr_addr got=%b exp=1001", {alu_src_a, alu_src_b}); end
            end
            if (c == 4) begin
                checks++; if ({result_src, pc_src, alu_src_a, alu_src_b} !== 7'b10_1_01_10)
                    begin failures++; $display("FAIL jalr_jump got=%b exp=1010110", {result_src, pc_src, alu_src_a, alu_src_b}); end
            end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        drive_reset();
        instruction = mk_instr(7'h7F);
        next_cycle();
        @(negedge clk);
        checks++; if (instr_retired !== 1'b0) begin failures++; $display("FAIL illegal_decode_retire got=%b exp=0", instr_retired); end
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom());
            branch_taken = 1'($urandom());
            @(negedge clk);
            checks++; if (strobes() !== 6'b0) begin failures++; $display("FAIL illegal_trap_strobes k=%0d got=%b exp=000000", k, strobes()); end
            checks++; if (fault !== 2'b01) begin failures++; $display("FAIL illegal_fault k=%0d got=%b exp=01", k, fault); end
            next_cycle();
        end
        rst_n = 1'b0;
        #2;
        checks++; if (fault !== 2'b00) begin failures++; $display("FAIL illegal_reset_fault got=%b exp=00", fault); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({mem_read, fault} !== 3'b100) begin failures++; $display("FAIL illegal_refetch got=%b exp=100", {mem_read, fault}); end
        next_cycle();
    endtask

    task automatic test_timeout();
        drive_reset();
        instruction = mk_instr(7'd51);
        mem_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++; if ({mem_read, ir_write, fault} !== 4'b1000) begin failures++; $display("FAIL timeout_wait c=%0d got=%b exp=1000", c, {mem_read, ir_write, fault}); end
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'($urandom());
            @(negedge clk);
            checks++; if (fault !== 2'b10) begin failures++; $display("FAIL timeout_fault k=%0d got=%b exp=10", k, fault); end
            checks++; if (strobes() !== 6'b0) begin failures++; $display("FAIL timeout_strobes k=%0d got=%b exp=000000", k, strobes()); end
            next_cycle();
        end
        drive_reset();
        for (int c = 1; c <= 16; c++) begin
            mem_ready = (c == 16);
            @(negedge clk);
            checks++; if ({mem_read, ir_write, fault} !== {1'b1, c == 16, 2'b00}) begin failures++; $display("FAIL timeout_last_ready c=%0d got=%b", c, {mem_read, ir_write, fault}); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if ({fault, mem_read, alu_src_a} !== 5'b00_0_01) begin failures++; $display("FAIL timeout_decode got=%b exp=00001", {fault, mem_read, alu_src_a}); end
        next_cycle();
    endtask

    task automatic test_abort();
        drive_reset();
        instruction = mk_instr(7'd3);
        for (int c = 1; c <= 3; c++) next_cycle();
        rst_n = 1'b0;
        #1;
        checks++; if (strobes() !== 6'b0) begin failures++; $display("FAIL abort_strobes got=%b exp=000000", strobes()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({mem_read, ir_write, instr_retired, adr_src} !== 4'b1100) begin failures++; $display("FAIL abort_refetch got=%b exp=1100", {mem_read, ir_write, instr_retired, adr_src}); end
        next_cycle();
    endtask

    // Reference: each opcode's cycle count and strobe totals come from the
    // instruction class plus the number of wait cycles in fetch and memory.
    task automatic test_random();
        logic [6:0] ops [9];
        ops = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};
        drive_reset();
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            int wf, wm, base, exp_rw, exp_pw, exp_mr, exp_mw, rw, pw, mr, mw, iw, ret_c, c;
            bit bt, done, is_ld, is_st;
            op = ops[$urandom_range(0, 8)];
            is_ld = (op == 7'd3);
            is_st = (op == 7'd35);
            wf = $urandom_range(0, 3);
            wm = (is_ld || is_st) ? $urandom_range(0, 3) : 0;
            bt = 1'($urandom());
            case (op)
                7'd55, 7'd23, 7'd99, 7'd111: base = 3;
                7'd3:                        base = 5;
                default:                     base = 4;
            endcase
            exp_rw = (is_st || op == 7'd99) ? 0 : 1;
            exp_pw = 1 + ((op == 7'd111 || op == 7'd103 || (op == 7'd99 && bt)) ? 1 : 0);
            exp_mr = wf + 1 + (is_ld ? wm + 1 : 0);
            exp_mw = is_st ? wm + 1 : 0;
            instruction = mk_instr(op);
            branch_taken = bt;
            rw = 0; pw = 0; mr = 0; mw = 0; iw = 0; ret_c = -1; done = 0; c = 0;
            while (!done && c < 40) begin
                mem_ready = !((c < wf) || (c >= wf + 3 && c < wf + 3 + wm));
                @(negedge clk);
                rw += int'(reg_write); pw += int'(pc_write); mr += int'(mem_read);
                mw += int'(mem_write); iw += int'(ir_write);
                if (instr_retired === 1'b1) begin done = 1; ret_c = c; end
                next_cycle();
                c++;
            end
            checks++; if (ret_c != base + wf + wm - 1) begin failures++; $display("FAIL rand_cycles n=%0d op=%0d got=%0d exp=%0d", n, op, ret_c + 1, base + wf + wm); end
            checks++; if ({rw, pw, mr, mw, iw} != {exp_rw, exp_pw, exp_mr, exp_mw, 1})
                begin failures++; $display("FAIL rand_counts n=%0d op=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/1", n, op, rw, pw, mr, mw, iw, exp_rw, exp_pw, exp_mr, exp_mw); end
            checks++; if (fault !== 2'b00) begin failures++; $display("FAIL rand_fault n=%0d got=%b exp=00", n, fault); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        instruction = 32'd0;
        #1;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_jalr();
        test_illegal();
        test_timeout();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
